sifive_id_queue_drain: RTL and testbench

Per-ID queue bank that accepts tagged requests on one enqueue port, stores them in NUM_IDS independent FIFOs, and drains them round-robin onto a single valid/ready output. It is the storage and drain side of the per-ID enqueue path whose invariant is "a valid enqueue to ID n only when queue n has space". It exports per-ID space flags to the initiator, and flags any violation of that invariant itself.

---
 rtl/sifive_id_queue_pkg.sv | 26 ++
 rtl/sifive_id_fifo.sv | 56 +++++
 rtl/sifive_id_queue_drain.sv | 95 +++++++++
 tb/tb_sifive_id_queue_drain.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sifive_id_queue_pkg.sv
// Shared types and helpers for the per-ID queue bank and its round-robin drain.
package sifive_id_queue_pkg;

  localparam int unsigned NUM_IDS = 4;
  localparam int unsigned ID_W    = 2;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    LOCK_OPEN,
    LOCK_HELD
  } lock_state_t;

  // First set bit of mask scanning ptr, ptr+1, ... modulo NUM_IDS; ptr when mask is empty.
  function automatic id_t rr_pick(input logic [NUM_IDS-1:0] mask, input id_t ptr);
    id_t idx;
    id_t pick;
    pick = ptr;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (mask[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sifive_id_fifo.sv
// Single DEPTH x DATA_W circular FIFO; push into a full or pop from an empty queue is ignored.
module sifive_id_fifo #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [DATA_W-1:0] mem [DEPTH];
  ptr_t              head_ptr;
  ptr_t              tail_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  function automatic ptr_t wrap_inc(input ptr_t p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[head_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) tail_ptr <= wrap_inc(tail_ptr);
      if (do_pop)  head_ptr <= wrap_inc(head_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset; count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[tail_ptr] <= din;
  end

endmodule

// File: rtl/sifive_id_queue_drain.sv
// Per-ID queue bank with round-robin drain, output lock under backpressure and overflow flag.
module sifive_id_queue_drain
  import sifive_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enq_valid,
  input  id_t                enq_id,
  input  logic [DATA_W-1:0]  enq_data,
  output logic [NUM_IDS-1:0] enq_ready_vec,
  output logic               enq_ready,
  output logic               deq_valid,
  input  logic               deq_ready,
  output id_t                deq_id,
  output logic [DATA_W-1:0]  deq_data,
  output logic               err_overflow
);

  logic [NUM_IDS-1:0] full;
  logic [NUM_IDS-1:0] empty;
  logic [NUM_IDS-1:0] push;
  logic [NUM_IDS-1:0] pop;
  logic [DATA_W-1:0]  head [NUM_IDS];

  lock_state_t state;
  lock_state_t state_nxt;
  id_t         lock_id;
  id_t         lock_id_nxt;
  id_t         rr_ptr;
  id_t         rr_ptr_nxt;
  id_t         grant;
  logic        enq_fire;
  logic        deq_fire;

  assign enq_ready_vec = ~full;
  assign enq_ready     = ~full[enq_id];
  assign enq_fire      = enq_valid & enq_ready;

  assign grant     = rr_pick(~empty, rr_ptr);
  assign deq_valid = (state == LOCK_HELD) | (|(~empty));
  assign deq_id    = (state == LOCK_HELD) ? lock_id : grant;
  assign deq_data  = head[deq_id];
  assign deq_fire  = deq_valid & deq_ready;

  for (genvar i = 0; i < NUM_IDS; i++) begin : g_q
    assign push[i] = enq_fire & (enq_id == ID_W'(i));
    assign pop[i]  = deq_fire & (deq_id == ID_W'(i));

    sifive_id_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push[i]),
      .pop     (pop[i]),
      .din     (enq_data),
      .full    (full[i]),
      .empty   (empty[i]),
      .head    (head[i])
    );
  end

  // Lock holds the presented beat stable until it is accepted.
  always_comb begin
    state_nxt   = state;
    lock_id_nxt = lock_id;
    rr_ptr_nxt  = rr_ptr;
    if (deq_fire) begin
      state_nxt  = LOCK_OPEN;
      rr_ptr_nxt = deq_id + ID_W'(1);
    end else if (deq_valid) begin
      state_nxt   = LOCK_HELD;
      lock_id_nxt = deq_id;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LOCK_OPEN;
      lock_id      <= '0;
      rr_ptr       <= '0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      lock_id      <= lock_id_nxt;
      rr_ptr       <= rr_ptr_nxt;
      err_overflow <= enq_valid & ~enq_ready;
    end
  end

endmodule

// File: tb/tb_sifive_id_queue_drain.sv
// Directed bench: table-driven vectors plus hand sequences for lock, full-pop and async reset.
module tb_sifive_id_queue_drain;

  logic        clock;
  logic        reset_n;
  logic        enq_valid;
  logic [1:0]  enq_id;
  logic [31:0] enq_data;
  logic [3:0]  enq_ready_vec;
  logic        enq_ready;
  logic        deq_valid;
  logic        deq_ready;
  logic [1:0]  deq_id;
  logic [31:0] deq_data;
  logic        err_overflow;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        ev;
    logic [1:0]  eid;
    logic [31:0] ed;
    logic        dr;
    logic        xdv;
    logic        xchk;
    logic [1:0]  xid;
    logic [31:0] xdata;
    logic [3:0]  xrvec;
    logic        xerdy;
    logic        xerr;
  } vec_t;

  vec_t vecs[$];

  sifive_id_queue_drain #(.DEPTH(2), .DATA_W(32)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enq_valid     (enq_valid),
    .enq_id        (enq_id),
    .enq_data      (enq_data),
    .enq_ready_vec (enq_ready_vec),
    .enq_ready     (enq_ready),
    .deq_valid     (deq_valid),
    .deq_ready     (deq_ready),
    .deq_id        (deq_id),
    .deq_data      (deq_data),
    .err_overflow  (err_overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ev, input logic [1:0] eid, input logic [31:0] ed,
                              input logic dr, input logic xdv, input logic xchk,
                              input logic [1:0] xid, input logic [31:0] xdata,
                              input logic [3:0] xrvec, input logic xerdy, input logic xerr);
    vec_t v;
    v.ev = ev; v.eid = eid; v.ed = ed; v.dr = dr;
    v.xdv = xdv; v.xchk = xchk; v.xid = xid; v.xdata = xdata;
    v.xrvec = xrvec; v.xerdy = xerdy; v.xerr = xerr;
    return v;
  endfunction

  task automatic drive(input logic ev, input logic [1:0] eid, input logic [31:0] ed, input logic dr);
    enq_valid = ev;
    enq_id    = eid;
    enq_data  = ed;
    deq_ready = dr;
  endtask

  initial begin
    clock = 1'b0;
    reset_n = 1'b0;
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_deq_valid", deq_valid, 0);
    check("rst_ready_vec", enq_ready_vec, 4'hF);
    check("rst_err", err_overflow, 0);
    check("rst_deq_id", deq_id, 0);

    // Overflow on ID2, then drain.
    vecs.push_back(mk(1, 2, 32'hA0, 0, 0, 0, 0, 32'h0,  4'hF, 1, 0));
    vecs.push_back(mk(1, 2, 32'hA1, 0, 1, 1, 2, 32'hA0, 4'hF, 1, 0));
    vecs.push_back(mk(1, 2, 32'hA2, 0, 1, 1, 2, 32'hA0, 4'hB, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 2, 32'hA0, 4'hB, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 2, 32'hA1, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  4'hF, 1, 0));
    // Round robin over all four IDs (rr_ptr starts at 3).
    vecs.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 32'h0,  4'hF, 1, 0));
    vecs.push_back(mk(1, 1, 32'h11, 0, 1, 1, 0, 32'h10, 4'hF, 1, 0));
    vecs.push_back(mk(1, 2, 32'h12, 0, 1, 1, 0, 32'h10, 4'hF, 1, 0));
    vecs.push_back(mk(1, 3, 32'h13, 0, 1, 1, 0, 32'h10, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 0, 32'h10, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 1, 32'h11, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 2, 32'h12, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 3, 32'h13, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 0, 0, 0, 32'h0,  4'hF, 1, 0));
    // IDs 1 and 3 loaded with rr_ptr=0.
    vecs.push_back(mk(1, 1, 32'h21, 0, 0, 0, 0, 32'h0,  4'hF, 1, 0));
    vecs.push_back(mk(1, 3, 32'h23, 0, 1, 1, 1, 32'h21, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 1, 32'h21, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  1, 1, 1, 3, 32'h23, 4'hF, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 0, 32'h0,  4'hF, 1, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clock);
      drive(vecs[k].ev, vecs[k].eid, vecs[k].ed, vecs[k].dr);
      #1;
      check($sformatf("v%0d_deq_valid", k), deq_valid, vecs[k].xdv);
      check($sformatf("v%0d_ready_vec", k), enq_ready_vec, vecs[k].xrvec);
      check($sformatf("v%0d_enq_ready", k), enq_ready, vecs[k].xerdy);
      check($sformatf("v%0d_err", k), err_overflow, vecs[k].xerr);
      if (vecs[k].xchk) begin
        check($sformatf("v%0d_deq_id", k), deq_id, vecs[k].xid);
        check($sformatf("v%0d_deq_data", k), deq_data, vecs[k].xdata);
      end
    end

    // Backpressure: ID1 stays presented while ID0 (higher priority) fills.
    @(negedge clock);
    drive(1'b1, 2'd1, 32'h55, 1'b0);
    @(negedge clock);
    drive(1'b1, 2'd0, 32'h66, 1'b0);
    #1;
    check("bp_first_id", deq_id, 1);
    check("bp_first_data", deq_data, 32'h55);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      drive(1'b0, 2'd0, 32'h0, 1'b0);
      #1;
      check($sformatf("bp_hold%0d_id", c), deq_id, 1);
      check($sformatf("bp_hold%0d_data", c), deq_data, 32'h55);
    end
    @(negedge clock);
    deq_ready = 1'b1;
    #1;
    check("bp_fire_data", deq_data, 32'h55);
    @(negedge clock);
    #1;
    check("bp_next_id", deq_id, 0);
    check("bp_next_data", deq_data, 32'h66);
    @(negedge clock);
    deq_ready = 1'b0;
    #1;
    check("bp_empty", deq_valid, 0);

    // Full ID3 refuses an enqueue even while popping.
    @(negedge clock);
    drive(1'b1, 2'd3, 32'h31, 1'b0);
    @(negedge clock);
    drive(1'b1, 2'd3, 32'h32, 1'b0);
    @(negedge clock);
    drive(1'b0, 2'd3, 32'h0, 1'b0);
    #1;
    check("fp_full_vec", enq_ready_vec, 4'h7);
    check("fp_id", deq_id, 3);
    @(negedge clock);
    drive(1'b1, 2'd3, 32'h33, 1'b1);
    #1;
    check("fp_enq_ready", enq_ready, 0);
    check("fp_data", deq_data, 32'h31);
    @(negedge clock);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    #1;
    check("fp_err", err_overflow, 1);
    check("fp_vec_after", enq_ready_vec, 4'hF);
    check("fp_head_after", deq_data, 32'h32);
    @(negedge clock);
    deq_ready = 1'b1;
    #1;
    check("fp_err_clear", err_overflow, 0);
    @(negedge clock);
    deq_ready = 1'b0;
    #1;
    check("fp_drained", deq_valid, 0);

    // Asynchronous reset while IDs 0 and 2 hold data and the output is locked.
    @(negedge clock);
    drive(1'b1, 2'd0, 32'h70, 1'b0);
    @(negedge clock);
    drive(1'b1, 2'd2, 32'h72, 1'b0);
    @(negedge clock);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    #1;
    check("mr_pre_valid", deq_valid, 1);
    check("mr_pre_id", deq_id, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check("mr_async_valid", deq_valid, 0);
    check("mr_async_vec", enq_ready_vec, 4'hF);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("mr_post_valid", deq_valid, 0);
    drive(1'b1, 2'd2, 32'h82, 1'b0);
    @(negedge clock);
    drive(1'b0, 2'd0, 32'h0, 1'b0);
    #1;
    check("mr_new_valid", deq_valid, 1);
    check("mr_new_id", deq_id, 2);
    check("mr_new_data", deq_data, 32'h82);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
